lcplc_stream_sequencer: RTL and testbench
=========================================

Name: lcplc_stream_sequencer

Overview:
Front-end controller for the LCPLC coder. Accepts one image configuration per image and a raw sample stream. Forwards the samples to the coder with the x_last_r/s/b/i framing flags, which it derives from its own position counters. Holds cfg_quant_shift and cfg_threshold stable for the whole image, so the coder never sees a configuration change mid-image.

Parameters:
DATA_WIDTH, 16, sample width
DIM_WIDTH, 12, width of the block rows/cols config fields
BAND_WIDTH, 10, width of the band count field
SLICE_CNT_WIDTH, 16, width of the slice count field
QUANTIZER_SHIFT_WIDTH, 4, width of the quantizer shift
THRESHOLD_WIDTH, 64, width of the threshold

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
cfg_valid  in  1  configuration offer
cfg_ready  out  1  configuration accepted when high with cfg_valid
cfg_block_rows  in  DIM_WIDTH  rows per slice block (1..max)
cfg_block_cols  in  DIM_WIDTH  columns per slice block (1..max)
cfg_bands  in  BAND_WIDTH  bands per slice (1..max)
cfg_slices  in  SLICE_CNT_WIDTH  slices per image (1..max)
cfg_quant_shift_in  in  QUANTIZER_SHIFT_WIDTH  quantizer shift for this image
cfg_threshold_in  in  THRESHOLD_WIDTH  threshold for this image
s_valid  in  1  raw sample valid
s_ready  out  1  raw sample ready
s_data  in  DATA_WIDTH  raw sample
x_valid  out  1  sample valid to coder
x_ready  in  1  coder ready
x_data  out  DATA_WIDTH  sample to coder
x_last_r  out  1  last sample of a row
x_last_b  out  1  last sample of a band within a slice
x_last_s  out  1  last sample of a slice
x_last_i  out  1  last sample of the image
cfg_quant_shift  out  QUANTIZER_SHIFT_WIDTH  held shift value, drives the coder
cfg_threshold  out  THRESHOLD_WIDTH  held threshold value, drives the coder
busy  out  1  high while in RUN
cfg_error  out  1  one-cycle pulse when a zero dimension is rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all counters=0.
  - cfg_quant_shift=0, cfg_threshold=0, held dimensions=0.
  - cfg_error=0, busy=0.
  - Combinational outputs follow the IDLE state.
- Sample order: slice-major, then band, then row, then column (col fastest).
- State IDLE:
  - cfg_ready=1, s_ready=0, x_valid=0.
  - On a cfg handshake, all cfg fields are registered.
  - If any of rows/cols/bands/slices is 0: cfg_error=1 for the next cycle, held quant/threshold stay unchanged, state stays IDLE.
  - Otherwise: quant/threshold outputs update, counters clear, state goes to RUN on the next cycle.
- State RUN:
  - cfg_ready=0; cfg_valid is ignored.
  - Pass-through with zero latency: x_valid=s_valid, s_ready=x_ready, x_data=s_data.
  - No output depends on x_valid->x_ready combinationally except s_ready.
- Flags (combinational from counters, qualified only by state=RUN):
  - x_last_r = (col==cols-1)
  - x_last_b = x_last_r & (row==rows-1)
  - x_last_s = x_last_b & (band==bands-1)
  - x_last_i = x_last_s & (slice==slices-1)
  - Flags are 0 in IDLE.
- Counter advance, only on a transfer (x_valid & x_ready):
  - col increments; it wraps to 0 on last_r.
  - row advances when col wraps.
  - band advances when row wraps.
  - slice advances when band wraps.
  - Counter widths match the config fields; no overflow is possible because the wrap compare precedes the increment.
- A transfer with x_last_i=1 sends the FSM to IDLE; cfg_ready=1 on the following cycle. There is no bubble besides that single config cycle.
- Stalls: with s_valid=0 or x_ready=0, counters and flags hold and outputs are unchanged.
- Reset mid-image: the partial image is discarded and the sequencer returns to IDLE. An upstream reset of the coder is required as well; this block does not issue it.

Test Plan:
- Config rows=2, cols=3, bands=2, slices=2, then 24 samples 0..23 with x_ready=1 -> required flags:
  - x_last_r at indices 2,5,8,11,14,17,20,23
  - x_last_b at 5,11,17,23
  - x_last_s at 11,23
  - x_last_i at 23 only
  - busy=0 and cfg_ready=1 one cycle after index 23.
- Same config with x_ready toggled 1-of-3 cycles and random s_valid gaps -> x_data sequence 0..23 is unchanged, flag positions are identical, and no sample is duplicated or dropped.
- Config with cols=0 -> cfg_error pulses exactly 1 cycle, state stays IDLE, s_ready=0, and held quant/threshold keep their previous values.
- cfg_valid asserted during RUN with quant_shift=7 -> cfg_ready=0 and cfg_quant_shift keeps its image value (e.g. 2) until index 23 completes. The pending cfg is then accepted and the output becomes 7.
- rst=0 asserted after sample 9 of a 24-sample image -> all outputs reach their reset values immediately. A new config rows=1, cols=1, bands=1, slices=1 with one sample -> all four flags are 1 on that sample.
- Two back-to-back images with 1x1x1x2 and 2x2x1x1 configs -> the second cfg is accepted on the cycle after the first last_i, and the flags are correct for both images.

Source files
------------

// File: rtl/lcplc_stream_sequencer.sv
// Front-end sequencer for the LCPLC coder: latches one image configuration,
// then streams raw samples through with row/band/slice/image framing flags.
module lcplc_stream_sequencer #(
    parameter int DATA_WIDTH            = 16,
    parameter int DIM_WIDTH             = 12,
    parameter int BAND_WIDTH            = 10,
    parameter int SLICE_CNT_WIDTH       = 16,
    parameter int QUANTIZER_SHIFT_WIDTH = 4,
    parameter int THRESHOLD_WIDTH       = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [DIM_WIDTH-1:0]             cfg_block_rows,
    input  logic [DIM_WIDTH-1:0]             cfg_block_cols,
    input  logic [BAND_WIDTH-1:0]            cfg_bands,
    input  logic [SLICE_CNT_WIDTH-1:0]       cfg_slices,
    input  logic [QUANTIZER_SHIFT_WIDTH-1:0] cfg_quant_shift_in,
    input  logic [THRESHOLD_WIDTH-1:0]       cfg_threshold_in,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    output logic                             x_valid,
    input  logic                             x_ready,
    output logic [DATA_WIDTH-1:0]            x_data,
    output logic                             x_last_r,
    output logic                             x_last_b,
    output logic                             x_last_s,
    output logic                             x_last_i,
    output logic [QUANTIZER_SHIFT_WIDTH-1:0] cfg_quant_shift,
    output logic [THRESHOLD_WIDTH-1:0]       cfg_threshold,
    output logic                             busy,
    output logic                             cfg_error
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state, state_next;
    logic [DIM_WIDTH-1:0]         rows, cols, row, col;
    logic [BAND_WIDTH-1:0]        bands, band;
    logic [SLICE_CNT_WIDTH-1:0]   slices, slice;

    logic run, cfg_accept, cfg_zero, cfg_start, xfer;

    assign run        = (state == RUN);
    assign cfg_accept = cfg_valid && (state == IDLE);
    assign cfg_zero   = (cfg_block_rows == '0) || (cfg_block_cols == '0) ||
                        (cfg_bands == '0) || (cfg_slices == '0);
    assign cfg_start  = cfg_accept && !cfg_zero;
    assign xfer       = run && s_valid && x_ready;

    // Flags are a pure function of the position counters, so a stalled
    // coder sees them unchanged until the sample is actually taken.
    assign x_last_r = run && (col == cols - 1'b1);
    assign x_last_b = x_last_r && (row == rows - 1'b1);
    assign x_last_s = x_last_b && (band == bands - 1'b1);
    assign x_last_i = x_last_s && (slice == slices - 1'b1);

    assign x_data = s_data;
    assign busy   = run;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        s_ready    = 1'b0;
        x_valid    = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_start) state_next = RUN;
            end
            RUN: begin
                x_valid = s_valid;
                s_ready = x_ready;
                if (xfer && x_last_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            rows            <= '0;
            cols            <= '0;
            bands           <= '0;
            slices          <= '0;
            row             <= '0;
            col             <= '0;
            band            <= '0;
            slice           <= '0;
            cfg_quant_shift <= '0;
            cfg_threshold   <= '0;
            cfg_error       <= 1'b0;
        end else begin
            state     <= state_next;
            cfg_error <= cfg_accept && cfg_zero;
            if (cfg_accept) begin
                rows   <= cfg_block_rows;
                cols   <= cfg_block_cols;
                bands  <= cfg_bands;
                slices <= cfg_slices;
            end
            if (cfg_start) begin
                cfg_quant_shift <= cfg_quant_shift_in;
                cfg_threshold   <= cfg_threshold_in;
                row             <= '0;
                col             <= '0;
                band            <= '0;
                slice           <= '0;
            end else if (xfer) begin
                // Each wrap is decided before incrementing, so a counter never
                // has to hold a value beyond its configured maximum.
                col <= x_last_r ? '0 : col + 1'b1;
                if (x_last_r) row   <= x_last_b ? '0 : row + 1'b1;
                if (x_last_b) band  <= x_last_s ? '0 : band + 1'b1;
                if (x_last_s) slice <= x_last_i ? '0 : slice + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcplc_stream_sequencer.sv
// Randomised scoreboard bench for lcplc_stream_sequencer: expected samples and
// flags come from index arithmetic over the image geometry.
module tb_lcplc_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready;
    logic [11:0] cfg_block_rows, cfg_block_cols;
    logic [9:0]  cfg_bands;
    logic [15:0] cfg_slices;
    logic [3:0]  cfg_quant_shift_in, cfg_quant_shift;
    logic [63:0] cfg_threshold_in, cfg_threshold;
    logic        s_valid, s_ready, x_valid, x_ready;
    logic [15:0] s_data, x_data;
    logic        x_last_r, x_last_b, x_last_s, x_last_i;
    logic        busy, cfg_error;

    lcplc_stream_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_block_rows(cfg_block_rows), .cfg_block_cols(cfg_block_cols),
        .cfg_bands(cfg_bands), .cfg_slices(cfg_slices),
        .cfg_quant_shift_in(cfg_quant_shift_in), .cfg_threshold_in(cfg_threshold_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .x_last_r(x_last_r), .x_last_b(x_last_b), .x_last_s(x_last_s), .x_last_i(x_last_i),
        .cfg_quant_shift(cfg_quant_shift), .cfg_threshold(cfg_threshold),
        .busy(busy), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  flags;   // {last_i, last_s, last_b, last_r}
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] img_base;
    logic [3:0]  cur_q;
    logic [63:0] cur_t;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    // Reference: flags follow from the linear sample index and block sizes.
    function automatic void push_model(int r, int c, int b, int s, logic [15:0] base);
        int total = r * c * b * s;
        for (int k = 0; k < total; k++) begin
            exp_t e;
            e.data     = base + 16'(k);
            e.flags[0] = (k % c) == c - 1;
            e.flags[1] = (k % (c * r)) == c * r - 1;
            e.flags[2] = (k % (c * r * b)) == c * r * b - 1;
            e.flags[3] = (k == total - 1);
            sb.push_back(e);
        end
    endfunction

    task automatic drive_cfg(int r, int c, int b, int s, logic [3:0] q, logic [63:0] t);
        cfg_block_rows     = 12'(r);
        cfg_block_cols     = 12'(c);
        cfg_bands          = 10'(b);
        cfg_slices         = 16'(s);
        cfg_quant_shift_in = q;
        cfg_threshold_in   = t;
        cfg_valid          = 1'b1;
    endtask

    // Called at posedge+1; completes one cfg handshake and checks its effect.
    task automatic apply_cfg(int r, int c, int b, int s, logic [3:0] q, logic [63:0] t,
                             logic [15:0] base);
        drive_cfg(r, c, b, s, q, t);
        #1;
        check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (r == 0 || c == 0 || b == 0 || s == 0) begin
            check("cfg_error_pulse", 64'(cfg_error), 64'd1);
            check("busy_after_bad_cfg", 64'(busy), 64'd0);
            check("quant_held_bad_cfg", 64'(cfg_quant_shift), 64'(cur_q));
            check("thresh_held_bad_cfg", cfg_threshold, cur_t);
        end else begin
            cur_q    = q;
            cur_t    = t;
            img_base = base;
            push_model(r, c, b, s, base);
            check("busy_after_cfg", 64'(busy), 64'd1);
            check("quant_loaded", 64'(cfg_quant_shift), 64'(q));
            check("thresh_loaded", cfg_threshold, t);
        end
    endtask

    // Offers samples start..start+n-1; a sample advances only on a handshake.
    task automatic send_samples(int n, int start, int gap_pct, bit slow_ready,
                                bit watch_pending);
        int  k      = start;
        int  cycles = 0;
        bit  fire;
        while (k < start + n) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = img_base + 16'(k);
            x_ready = slow_ready ? ($urandom_range(2) == 0) : 1'b1;
            #1;
            if (watch_pending) begin
                check("cfg_ready_run", 64'(cfg_ready), 64'd0);
                check("quant_stable_run", 64'(cfg_quant_shift), 64'(cur_q));
            end
            fire = s_valid && s_ready;
            @(posedge clk); #1;
            if (fire) k++;
            if (++cycles > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sent %0d of %0d samples", k - start, n);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic check_idle(string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    endtask

    // Monitor: every completed transfer must match the next modelled sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && x_valid && x_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got data 0x%0h expected no transfer", x_data);
                end else begin
                    e = sb.pop_front();
                    check("x_data", 64'(x_data), 64'(e.data));
                    check("x_flags", 64'({x_last_i, x_last_s, x_last_b, x_last_r}), 64'(e.flags));
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        s_valid   = 1'b0;
        x_ready   = 1'b0;
        s_data    = '0;
        cur_q     = '0;
        cur_t     = '0;
        img_base  = '0;
        drive_cfg(0, 0, 0, 0, 4'd0, 64'd0);
        cfg_valid = 1'b0;
        #3;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_x_valid", 64'(x_valid), 64'd0);
        check("rst_cfg_error", 64'(cfg_error), 64'd0);
        check("rst_quant", 64'(cfg_quant_shift), 64'd0);
        check("rst_thresh", cfg_threshold, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic 2x3x2x2 image, full throughput.
        apply_cfg(2, 3, 2, 2, 4'd2, 64'h0123_4567_89ab_cdef, 16'd0);
        send_samples(24, 0, 0, 1'b0, 1'b0);
        check_idle("img1_end");

        // Same geometry with source gaps and a slow coder.
        apply_cfg(2, 3, 2, 2, 4'd3, {$urandom, $urandom}, 16'd0);
        send_samples(24, 0, 30, 1'b1, 1'b0);
        check_idle("img2_end");
        check("img2_drained", 64'(sb.size()), 64'd0);

        // A zero dimension is rejected for exactly one cycle.
        apply_cfg(2, 0, 2, 2, 4'd9, 64'hdead_beef, 16'd0);
        x_ready = 1'b1;
        s_valid = 1'b1;
        #1;
        check("bad_cfg_s_ready", 64'(s_ready), 64'd0);
        check("bad_cfg_x_valid", 64'(x_valid), 64'd0);
        s_valid = 1'b0;
        @(posedge clk); #1;
        check("cfg_error_one_cycle", 64'(cfg_error), 64'd0);
        check("bad_cfg_still_idle", 64'(busy), 64'd0);

        // Config offered mid-image waits until the image completes.
        apply_cfg(2, 3, 2, 2, 4'd2, 64'h55, 16'h1000);
        drive_cfg(1, 1, 1, 1, 4'd7, 64'h77);
        send_samples(24, 0, 20, 1'b1, 1'b1);
        check("pending_cfg_ready", 64'(cfg_ready), 64'd1);
        check("pending_quant_kept", 64'(cfg_quant_shift), 64'd2);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cur_q     = 4'd7;
        cur_t     = 64'h77;
        img_base  = 16'h2000;
        push_model(1, 1, 1, 1, img_base);
        check("pending_quant_loaded", 64'(cfg_quant_shift), 64'd7);
        check("pending_busy", 64'(busy), 64'd1);
        send_samples(1, 0, 0, 1'b0, 1'b0);
        check_idle("pending_end");

        // Reset in the middle of an image discards the rest of it.
        apply_cfg(2, 3, 2, 2, 4'd5, 64'h99, 16'h3000);
        send_samples(10, 0, 0, 1'b0, 1'b0);
        s_valid = 1'b1;
        rst     = 1'b0;
        #1;
        sb.delete();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("midrst_x_valid", 64'(x_valid), 64'd0);
        check("midrst_flags", 64'({x_last_i, x_last_s, x_last_b, x_last_r}), 64'd0);
        check("midrst_quant", 64'(cfg_quant_shift), 64'd0);
        check("midrst_thresh", cfg_threshold, 64'd0);
        s_valid = 1'b0;
        cur_q   = '0;
        cur_t   = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        apply_cfg(1, 1, 1, 1, 4'd1, 64'h1, 16'h4000);
        send_samples(1, 0, 0, 1'b0, 1'b0);
        check_idle("single_end");

        // Back-to-back images: second cfg lands the cycle after last_i.
        apply_cfg(1, 1, 1, 2, 4'd4, 64'h44, 16'h5000);
        send_samples(2, 0, 0, 1'b0, 1'b0);
        apply_cfg(2, 2, 1, 1, 4'd6, 64'h66, 16'h6000);
        send_samples(4, 0, 0, 1'b0, 1'b0);
        check_idle("b2b_end");

        // Random small geometries with random backpressure.
        for (int n = 0; n < 4; n++) begin
            int r = $urandom_range(1, 3);
            int c = $urandom_range(1, 4);
            int b = $urandom_range(1, 3);
            int s = $urandom_range(1, 2);
            apply_cfg(r, c, b, s, 4'($urandom), {$urandom, $urandom}, 16'($urandom));
            send_samples(r * c * b * s, 0, 25, 1'b1, 1'b0);
            check_idle("rand_end");
        end

        @(posedge clk); #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
